// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Holds uart_send for SEND_HOLD cycles, then waits for a rising edge of uart_tx_done or a timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int SEND_HOLD   = 220,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic                         req_err,
    output logic                         uart_send,
    output logic [DATA_W-1:0]            uart_din,
    input  logic                         uart_tx_done,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic [7:0]                   timeout_cnt
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(SEND_HOLD + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;

    logic [2:0]         r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [HOLD_W-1:0]  r_hold;
    logic [TO_W-1:0]    r_to;
    logic               r_done_q;

    logic               w_done_rise;
    logic               w_found;
    logic [ID_W-1:0]    w_pick_id;
    logic [ID_W-1:0]    w_idx;
    logic [NUM_REQ-1:0] w_ack_vec;

    // The transmitter's done is a long level on a slower clock; only its rising edge completes a byte.
    assign w_done_rise = uart_tx_done & ~r_done_q;

    // First pending requester at or after r_rr_ptr, wrapping around.
    always_comb begin
        w_found   = 1'b0;
        w_pick_id = '0;
        w_idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found   = 1'b1;
                w_pick_id = w_idx;
            end
        end
    end

    always_comb begin
        w_ack_vec           = '0;
        w_ack_vec[grant_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_hold      <= '0;
            r_to        <= '0;
            r_done_q    <= 1'b0;
            uart_send   <= 1'b0;
            uart_din    <= '0;
            req_ack     <= '0;
            req_err     <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            timeout_cnt <= '0;
        end else begin
            r_done_q <= uart_tx_done;
            req_ack  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state <= S_GRANT;
                        busy    <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (w_found) begin
                        grant_id  <= w_pick_id;
                        uart_din  <= req_data[w_pick_id*DATA_W +: DATA_W];
                        r_hold    <= HOLD_W'(SEND_HOLD - 1);
                        uart_send <= 1'b1;
                        r_state   <= S_SEND;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (r_hold == '0) begin
                        uart_send <= 1'b0;
                        r_to      <= TO_W'(TIMEOUT_CYC - 1);
                        r_state   <= S_WAIT;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                S_WAIT: begin
                    // A rise on the last timeout cycle still counts as success.
                    if (w_done_rise || r_to == '0) begin
                        r_state <= S_ACK;
                        req_ack <= w_ack_vec;
                        req_err <= ~w_done_rise;
                        if (!w_done_rise && timeout_cnt != 8'hFF)
                            timeout_cnt <= timeout_cnt + 8'd1;
                    end else begin
                        r_to <= r_to - TO_W'(1);
                    end
                end
                S_ACK: begin
                    req_err  <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                    r_rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                end
                default: begin
                    r_state   <= S_IDLE;
                    uart_send <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a behavioural transmitter model.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int SH = 20;
    localparam int TO = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]   req_ack;
    logic            req_err;
    logic            uart_send;
    logic [DW-1:0]   uart_din;
    logic            uart_tx_done = 1'b0;
    logic            busy;
    logic [1:0]      grant_id;
    logic [7:0]      timeout_cnt;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .DATA_W(DW),
        .SEND_HOLD(SH),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .req_ack(req_ack),
        .req_err(req_err),
        .uart_send(uart_send),
        .uart_din(uart_din),
        .uart_tx_done(uart_tx_done),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
        int err;
        int lat;
        int tos;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] bq[NR][$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_ptr = 0;
    int m_to  = 0;
    int tx_mode = 0;
    int tx_dly  = 0;
    int tx_w    = 1;
    bit abort_send = 1'b0;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transmitter model: 1 = done pulse tx_dly cycles after send falls;
    // 2 = done already high during send, drops 3 cycles after send falls, rises tx_dly later.
    initial forever begin
        @(negedge clk);
        if (uart_send) begin
            if (tx_mode == 2) uart_tx_done = 1'b1;
            while (uart_send) @(negedge clk);
            if (tx_mode == 1) begin
                repeat (tx_dly) @(negedge clk);
                uart_tx_done = 1'b1;
                repeat (tx_w) @(negedge clk);
                uart_tx_done = 1'b0;
            end else if (tx_mode == 2) begin
                repeat (3) @(negedge clk);
                uart_tx_done = 1'b0;
                repeat (tx_dly) @(negedge clk);
                uart_tx_done = 1'b1;
                repeat (tx_w) @(negedge clk);
                uart_tx_done = 1'b0;
            end
        end
    end

    // Requester driver: hold req while bytes remain, present the next byte after each ack.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i] && bq[i].size() > 0) begin
                void'(bq[i].pop_front());
                if (bq[i].size() == 0) req[i] = 1'b0;
                else req_data[i*DW +: DW] = bq[i][0];
            end
        end
    end

    // Monitor
    initial begin : mon
        exp_t e;
        int idle_cyc;
        int hi;
        bit post;
        int post_to;
        idle_cyc = 0;
        hi = 0;
        post = 1'b0;
        post_to = 0;
        forever begin
            @(negedge clk);
            if (post) begin
                chk("busy_after_ack", int'(busy), 0);
                chk("timeout_cnt", int'(timeout_cnt), post_to);
                post = 1'b0;
            end
            if (!busy) idle_cyc = cyc;
            if (uart_send) begin
                if (hi == 0 && sb.size() > 0) begin
                    chk("din_at_send", int'(uart_din), sb[0].data);
                    chk("gid_at_send", int'(grant_id), sb[0].id);
                end
                hi++;
            end else if (hi != 0) begin
                if (!abort_send) chk("send_len", hi, SH);
                hi = 0;
                abort_send = 1'b0;
            end
            if (req_ack != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", int'(req_ack), 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_vec", int'(req_ack), 1 << e.id);
                    chk("ack_gid", int'(grant_id), e.id);
                    chk("ack_din", int'(uart_din), e.data);
                    chk("ack_err", int'(req_err), e.err);
                    chk("ack_latency", cyc - idle_cyc, e.lat);
                    post = 1'b1;
                    post_to = e.tos;
                end
            end
        end
    end

    // Reference model: plays out round-robin over the queued bytes and predicts each outcome.
    task automatic issue(input int md, input int dly, input int w);
        int used[NR];
        int n, id, err, lat, c;
        exp_t e;
        c = 0;
        while (uart_tx_done && c < 400) begin
            @(negedge clk);
            c++;
        end
        tx_mode = md;
        tx_dly  = dly;
        tx_w    = w;
        if (md == 0 || (md == 1 && dly > TO - 1)) begin
            err = 1; lat = SH + TO + 2;
        end else if (md == 1) begin
            err = 0; lat = SH + dly + 3;
        end else begin
            err = 0; lat = SH + dly + 6;
        end
        n = 0;
        for (int i = 0; i < NR; i++) begin
            used[i] = 0;
            n += bq[i].size();
        end
        repeat (n) begin
            id = -1;
            for (int k = 0; k < NR; k++)
                if (id < 0 && used[(m_ptr + k) % NR] < bq[(m_ptr + k) % NR].size())
                    id = (m_ptr + k) % NR;
            e.id   = id;
            e.data = int'(bq[id][used[id]]);
            e.err  = err;
            e.lat  = lat;
            used[id]++;
            if (err == 1 && m_to < 255) m_to++;
            e.tos = m_to;
            sb.push_back(e);
            m_ptr = (id + 1) % NR;
        end
        for (int i = 0; i < NR; i++) begin
            if (bq[i].size() > 0) begin
                req_data[i*DW +: DW] = bq[i][0];
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_done();
        int c, budget;
        c = 0;
        budget = (sb.size() + 1) * (SH + TO + 12) + 50;
        while ((sb.size() != 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) begin
            total++;
            bad++;
            $display("FAIL batch_bound: %0d transfers outstanding, busy=%0d after %0d cycles", sb.size(), busy, c);
            sb.delete();
            for (int i = 0; i < NR; i++) bq[i].delete();
            req = '0;
        end
    endtask

    task automatic wait_send();
        int c;
        c = 0;
        while (!uart_send && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("send_start", int'(uart_send), 1);
    endtask

    initial begin
        int md, dly, n;
        repeat (3) @(negedge clk);
        chk("rst_send", int'(uart_send), 0);
        chk("rst_ack", int'(req_ack), 0);
        chk("rst_err", int'(req_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_gid", int'(grant_id), 0);
        chk("rst_din", int'(uart_din), 0);
        chk("rst_tocnt", int'(timeout_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        // Round-robin with all requesters pending
        bq[0].push_back(8'h10); bq[0].push_back(8'h10);
        bq[1].push_back(8'h11);
        bq[2].push_back(8'h12);
        bq[3].push_back(8'h13);
        issue(1, 4, 3);
        wait_done();

        // Single request; req dropped and data changed after grant
        bq[2].push_back(8'hA5);
        issue(1, 40, 30);
        wait_send();
        req_data[23:16] = 8'h5A;
        req[2] = 1'b0;
        wait_done();

        // Reset during SEND aborts; transfer is re-arbitrated and completes
        bq[1].push_back(8'h77);
        issue(1, 8, 4);
        wait_send();
        repeat (5) @(negedge clk);
        abort_send = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        m_to = 0;
        chk("midrst_send", int'(uart_send), 0);
        chk("midrst_ack", int'(req_ack), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_tocnt", int'(timeout_cnt), m_to);
        rst = 1'b0;
        wait_done();

        // Stale done level across WAIT entry
        bq[3].push_back(8'hC3);
        issue(2, 30, 5);
        wait_done();

        // Timeout with done tied low
        bq[0].push_back(8'h01);
        issue(0, 0, 1);
        wait_done();

        // Rise on the last timeout cycle succeeds; one cycle later it is a timeout
        bq[1].push_back(8'hE7);
        issue(1, TO - 1, 3);
        wait_done();
        bq[2].push_back(8'h3C);
        issue(1, TO, 3);
        wait_done();

        // Random batches
        for (int b = 0; b < 8; b++) begin
            n = 0;
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 3)) begin
                        bq[i].push_back(8'($urandom));
                        n++;
                    end
                end
            end
            if (n == 0) bq[$urandom_range(0, NR - 1)].push_back(8'($urandom));
            md  = int'($urandom_range(1, 2));
            dly = (md == 1) ? int'($urandom_range(0, TO - 1)) : int'($urandom_range(1, TO - 10));
            issue(md, dly, int'($urandom_range(1, 10)));
            wait_done();
        end

        // Timeout counter saturation
        for (int i = 0; i < 257; i++) bq[0].push_back(8'(i));
        issue(0, 0, 1);
        wait_done();
        chk("tocnt_saturated", int'(timeout_cnt), 255);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
